// File: rtl/riscv_mem_stage_pkg.sv
// Shared configuration for the MEM stage: default data width, RISC-V
// load/store funct3 encodings and the bus FSM state encodings.
package riscv_configs;

    localparam int XLEN_DEFAULT = 32;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Data bus FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational load/store alignment unit.
//  Store side : byte enables (size mask shifted to the addressed lane) and
//               store data replicated across every lane of the bus word.
//  Check      : flags misaligned addresses and funct3 codes illegal for XLEN.
//  Load side  : selects the addressed lane of rdata using the offset/funct3
//               latched at grant, then sign- or zero-extends it.
// Ports
//  funct3, is_store, addr_lo, store_data -> be, wdata, misalign
//  load_funct3, load_offset, rdata       -> load_data
module riscv_lsu_align
    import riscv_configs::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]                funct3,
    input  logic                      is_store,
    input  logic [2:0]                addr_lo,
    input  logic [XLEN-1:0]           store_data,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           wdata,
    output logic                      misalign,
    input  logic [2:0]                load_funct3,
    input  logic [$clog2(XLEN/8)-1:0] load_offset,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN-1:0]           load_data
);

    localparam int NB      = XLEN / 8;
    localparam int OFF_W   = $clog2(NB);
    localparam bit IS_RV64 = (XLEN == 64);

    logic          legal;
    logic          aligned;
    logic [NB-1:0] size_mask;
    logic [XLEN-1:0] lane;

    // Legality and natural alignment of the access in MEM.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        if (is_store)
            legal = (funct3 inside {F3_SB, F3_SH, F3_SW}) || (IS_RV64 && funct3 == F3_SD);
        else
            legal = (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) ||
                    (IS_RV64 && (funct3 inside {F3_LD, F3_LWU}));
        // funct3[1:0] encodes the access size for both loads and stores
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = (addr_lo[0] == 1'b0);
            2'b10:   aligned = (addr_lo[1:0] == 2'b00);
            default: aligned = (addr_lo == 3'b000);
        endcase
        misalign = ~(legal & aligned);
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        size_mask = '0;
        wdata     = store_data;
        case (funct3[1:0])
            2'b00: begin
                size_mask = NB'(8'h01);
                wdata     = {NB{store_data[7:0]}};
            end
            2'b01: begin
                size_mask = NB'(8'h03);
                wdata     = {(NB/2){store_data[15:0]}};
            end
            2'b10: begin
                size_mask = NB'(8'h0F);
                wdata     = {(NB/4){store_data[31:0]}};
            end
            default: begin
                size_mask = '1;
                wdata     = store_data;
            end
        endcase
        be = size_mask << addr_lo[OFF_W-1:0];
    end

    // Load lane select and extension; a signed size cast sign-extends.
    always_comb begin
        lane      = rdata >> {load_offset, 3'b000};
        load_data = lane;
        case (load_funct3)
            F3_LB:   load_data = XLEN'($signed(lane[7:0]));
            F3_LH:   load_data = XLEN'($signed(lane[15:0]));
            F3_LW:   load_data = XLEN'($signed(lane[31:0]));
            F3_LBU:  load_data = XLEN'(lane[7:0]);
            F3_LHU:  load_data = XLEN'(lane[15:0]);
            F3_LWU:  load_data = XLEN'(lane[31:0]);
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/riscv_mem_stage.sv
// Pipelined MEM stage with MEM/WB register. Runs one req/gnt/rvalid data bus
// transaction per memory instruction and stalls IF..MEM until it completes.
// Ports
//  i_clk, i_rstn                       clock, async active-low reset
//  i_*_m                               instruction in MEM (held stable while o_stall_m)
//  i_flush_m                           kill the instruction in MEM
//  o_stall_m                           hold IF..MEM
//  o_dbus_* / i_dbus_*                 data bus master side
//  o_*_w                               MEM/WB register outputs
module riscv_mem_stage
    import riscv_configs::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int RADDR_W = 5
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_valid_m,
    input  logic                i_reg_write_m,
    input  logic [1:0]          i_result_src_m,
    input  logic                i_mem_read_m,
    input  logic                i_mem_write_m,
    input  logic [2:0]          i_funct3_m,
    input  logic [XLEN-1:0]     i_alu_result_m,
    input  logic [XLEN-1:0]     i_write_data_m,
    input  logic [RADDR_W-1:0]  i_rd_m,
    input  logic [XLEN-1:0]     i_pc_plus_4m,
    input  logic                i_flush_m,
    output logic                o_stall_m,
    output logic                o_dbus_req,
    output logic                o_dbus_we,
    output logic [XLEN-1:0]     o_dbus_addr,
    output logic [XLEN/8-1:0]   o_dbus_be,
    output logic [XLEN-1:0]     o_dbus_wdata,
    input  logic                i_dbus_gnt,
    input  logic                i_dbus_rvalid,
    input  logic [XLEN-1:0]     i_dbus_rdata,
    output logic                o_valid_w,
    output logic                o_reg_write_w,
    output logic [1:0]          o_result_src_w,
    output logic [XLEN-1:0]     o_alu_result_w,
    output logic [XLEN-1:0]     o_read_data_w,
    output logic [RADDR_W-1:0]  o_rd_w,
    output logic [XLEN-1:0]     o_pc_plus_4w,
    output logic                o_misalign_w
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [1:0]        state, state_next;
    logic              kill, kill_next;
    logic [OFF_W-1:0]  load_offset;
    logic [2:0]        load_funct3;

    logic [NB-1:0]     be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   load_data;
    logic              bad_access;

    logic mem_op, misaligned, access, req, done, busy, stall, wb_valid;

    riscv_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3      (i_funct3_m),
        .is_store    (i_mem_write_m),
        .addr_lo     (i_alu_result_m[2:0]),
        .store_data  (i_write_data_m),
        .be          (be),
        .wdata       (wdata),
        .misalign    (bad_access),
        .load_funct3 (load_funct3),
        .load_offset (load_offset),
        .rdata       (i_dbus_rdata),
        .load_data   (load_data)
    );

    always_comb begin
        mem_op     = i_valid_m & (i_mem_read_m | i_mem_write_m);
        misaligned = mem_op & bad_access;
        access     = mem_op & ~bad_access;
        req        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        state_next = state;
        case (state)
            ST_IDLE: begin
                req  = access;
                busy = access;
                if (access) begin
                    if (!i_dbus_gnt)        state_next = ST_REQ;
                    else if (i_mem_write_m) done       = 1'b1;
                    else                    state_next = ST_RESP;
                end
            end
            ST_REQ: begin
                // request stays up until granted; it is never withdrawn
                req  = 1'b1;
                busy = 1'b1;
                if (i_dbus_gnt) begin
                    if (i_mem_write_m) begin
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                busy = 1'b1;
                if (i_dbus_rvalid) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        stall     = busy & ~done;
        // a flushed transaction still runs to completion; only its WB slot is killed
        kill_next = (state_next == ST_IDLE) ? 1'b0 : (kill | i_flush_m);
        wb_valid  = i_valid_m & ~i_flush_m & ~kill;
    end

    // Bus and stall are gated by reset so they drop immediately even though
    // the MEM inputs may still describe an access while reset is held.
    assign o_dbus_req   = req & i_rstn;
    assign o_stall_m    = stall & i_rstn;
    assign o_dbus_we    = o_dbus_req & i_mem_write_m;
    assign o_dbus_be    = o_dbus_req ? be : '0;
    assign o_dbus_addr  = {i_alu_result_m[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign o_dbus_wdata = wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the lane latches and MEM/WB data fields are reset too, so WB shows all-zero out of reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= ST_IDLE;
            kill           <= 1'b0;
            load_offset    <= '0;
            load_funct3    <= '0;
            o_valid_w      <= 1'b0;
            o_reg_write_w  <= 1'b0;
            o_result_src_w <= '0;
            o_alu_result_w <= '0;
            o_read_data_w  <= '0;
            o_rd_w         <= '0;
            o_pc_plus_4w   <= '0;
            o_misalign_w   <= 1'b0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
            // lane offset and extension type are taken at grant for the later rvalid
            if (req && i_dbus_gnt) begin
                load_offset <= i_alu_result_m[OFF_W-1:0];
                load_funct3 <= i_funct3_m;
            end
            o_result_src_w <= i_result_src_m;
            o_alu_result_w <= i_alu_result_m;
            o_read_data_w  <= load_data;
            o_rd_w         <= i_rd_m;
            o_pc_plus_4w   <= i_pc_plus_4m;
            if (stall) begin
                o_valid_w     <= 1'b0;
                o_reg_write_w <= 1'b0;
                o_misalign_w  <= 1'b0;
            end else begin
                o_valid_w     <= wb_valid;
                o_reg_write_w <= wb_valid & i_reg_write_m & ~misaligned;
                o_misalign_w  <= wb_valid & misaligned;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Scoreboard bench for riscv_mem_stage (XLEN = 32). Each operation pushes
// its expected MEM/WB result, plays a bus slave with programmable grant and
// rvalid latency, and pops/compares once the stage stops stalling.
module tb_riscv_mem_stage;

    localparam int XLEN = 32;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_valid_m, i_reg_write_m, i_mem_read_m, i_mem_write_m, i_flush_m;
    logic [1:0]  i_result_src_m;
    logic [2:0]  i_funct3_m;
    logic [31:0] i_alu_result_m, i_write_data_m, i_pc_plus_4m;
    logic [4:0]  i_rd_m;
    logic        o_stall_m, o_dbus_req, o_dbus_we;
    logic [31:0] o_dbus_addr, o_dbus_wdata;
    logic [3:0]  o_dbus_be;
    logic        i_dbus_gnt, i_dbus_rvalid;
    logic [31:0] i_dbus_rdata;
    logic        o_valid_w, o_reg_write_w, o_misalign_w;
    logic [1:0]  o_result_src_w;
    logic [31:0] o_alu_result_w, o_read_data_w, o_pc_plus_4w;
    logic [4:0]  o_rd_w;

    riscv_mem_stage #(.XLEN(XLEN), .RADDR_W(5)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid_m(i_valid_m), .i_reg_write_m(i_reg_write_m),
        .i_result_src_m(i_result_src_m), .i_mem_read_m(i_mem_read_m), .i_mem_write_m(i_mem_write_m),
        .i_funct3_m(i_funct3_m), .i_alu_result_m(i_alu_result_m), .i_write_data_m(i_write_data_m),
        .i_rd_m(i_rd_m), .i_pc_plus_4m(i_pc_plus_4m), .i_flush_m(i_flush_m), .o_stall_m(o_stall_m),
        .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr), .o_dbus_be(o_dbus_be),
        .o_dbus_wdata(o_dbus_wdata), .i_dbus_gnt(i_dbus_gnt), .i_dbus_rvalid(i_dbus_rvalid),
        .i_dbus_rdata(i_dbus_rdata), .o_valid_w(o_valid_w), .o_reg_write_w(o_reg_write_w),
        .o_result_src_w(o_result_src_w), .o_alu_result_w(o_alu_result_w), .o_read_data_w(o_read_data_w),
        .o_rd_w(o_rd_w), .o_pc_plus_4w(o_pc_plus_4w), .o_misalign_w(o_misalign_w)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  f3;
        bit          ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        int          flush_cyc;
    } op_t;

    typedef struct {
        bit          valid;
        bit          reg_write;
        bit          misalign;
        bit          is_load;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] rdata;
        int          stalls;
    } wb_t;

    wb_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_bad(input logic [2:0] f3, input logic [31:0] a, input bit st);
        bit legal, al;
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        case (f3[1:0])
            2'b01:   al = (a[0] == 1'b0);
            2'b10:   al = (a[1:0] == 2'b00);
            2'b11:   al = (a[2:0] == 3'b000);
            default: al = 1'b1;
        endcase
        return !(legal && al);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a[1:0];
            2'b01:   return 4'b0011 << a[1:0];
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] lane;
        lane = d >> (8 * a[1:0]);
        case (f3)
            3'd0:    return {{24{lane[7]}}, lane[7:0]};
            3'd1:    return {{16{lane[15]}}, lane[15:0]};
            3'd4:    return {24'h0, lane[7:0]};
            3'd5:    return {16'h0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    function automatic op_t mk(input logic [2:0] f3, input bit ld, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] rdata,
                               input int gd, input int rv, input int fc);
        op_t o;
        o.f3 = f3; o.ld = ld; o.addr = addr; o.data = data; o.rdata = rdata;
        o.gnt_dly = gd; o.rv_dly = rv; o.flush_cyc = fc;
        return o;
    endfunction

    task automatic idle_inputs();
        i_valid_m = 0; i_reg_write_m = 0; i_mem_read_m = 0; i_mem_write_m = 0; i_flush_m = 0;
        i_result_src_m = 0; i_funct3_m = 0; i_alu_result_m = 0; i_write_data_m = 0;
        i_rd_m = 0; i_pc_plus_4m = 0; i_dbus_gnt = 0; i_dbus_rvalid = 0; i_dbus_rdata = 0;
    endtask

    // Drive one MEM instruction (entered at posedge+1) and act as the bus slave.
    task automatic run_op(input op_t op);
        wb_t e, got;
        bit  bad, granted, fin;
        int  cyc, since, waited, stalls;
        bad = is_bad(op.f3, op.addr, !op.ld);
        granted = 0; fin = 0; cyc = 0; since = 0; waited = 0; stalls = 0;

        i_valid_m      = 1;
        i_mem_read_m   = op.ld;
        i_mem_write_m  = !op.ld;
        i_reg_write_m  = op.ld;
        i_funct3_m     = op.f3;
        i_alu_result_m = op.addr;
        i_write_data_m = op.data;
        i_rd_m         = op.addr[6:2] ^ 5'h15;
        i_result_src_m = op.ld ? 2'b01 : 2'b10;
        i_pc_plus_4m   = op.addr ^ 32'h8000_0004;

        e.valid     = (op.flush_cyc < 0);
        e.misalign  = e.valid && bad;
        e.reg_write = e.valid && op.ld && !bad;
        e.is_load   = op.ld && !bad;
        e.alu = op.addr; e.pc = i_pc_plus_4m; e.rd = i_rd_m; e.src = i_result_src_m;
        e.rdata     = exp_load(op.f3, op.addr, op.rdata);
        e.stalls    = bad ? 0 : op.gnt_dly + (op.ld ? op.rv_dly : 0);
        sb.push_back(e);

        while (!fin && cyc < 40) begin
            i_dbus_gnt    = 0;
            i_dbus_rvalid = 0;
            i_dbus_rdata  = 32'hA5A5_A5A5;
            i_flush_m     = (cyc == op.flush_cyc);
            if (granted) begin
                since++;
                if (since == op.rv_dly) begin
                    i_dbus_rvalid = 1;
                    i_dbus_rdata  = op.rdata;
                end
            end
            #1;
            if (bad) check("no_req_on_bad", o_dbus_req, 0);
            else if (!granted) begin
                check("req_held", o_dbus_req, 1);
                check("dbus_addr", o_dbus_addr, {op.addr[31:2], 2'b00});
                check("dbus_we", o_dbus_we, !op.ld);
                if (!op.ld) begin
                    check("dbus_be", o_dbus_be, exp_be(op.f3, op.addr));
                    check("dbus_wdata", o_dbus_wdata, exp_wdata(op.f3, op.data));
                end
                if (waited == op.gnt_dly) i_dbus_gnt = 1;
                else waited++;
            end else begin
                check("req_low_in_resp", o_dbus_req, 0);
            end
            @(negedge i_clk);
            if (o_stall_m) stalls++;
            if (o_stall_m && cyc > 0) check("wb_bubble_in_stall", o_valid_w, 0);
            fin = !o_stall_m;
            if (i_dbus_gnt && o_dbus_req) granted = op.ld;
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check("op_done", fin, 1);
        idle_inputs();

        got = sb.pop_front();
        check("stall_cycles", stalls, got.stalls);
        check("wb_valid", o_valid_w, got.valid);
        check("wb_reg_write", o_reg_write_w, got.reg_write);
        check("wb_misalign", o_misalign_w, got.misalign);
        if (got.valid) begin
            check("wb_alu", o_alu_result_w, got.alu);
            check("wb_pc4", o_pc_plus_4w, got.pc);
            check("wb_rd", o_rd_w, got.rd);
            check("wb_src", o_result_src_w, got.src);
            if (got.is_load) check("wb_read_data", o_read_data_w, got.rdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        op_t o;
        idle_inputs();
        i_rstn = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid_w", o_valid_w, 0);
        check("rst_reg_write_w", o_reg_write_w, 0);
        check("rst_misalign_w", o_misalign_w, 0);
        check("rst_read_data_w", o_read_data_w, 0);
        check("rst_req", o_dbus_req, 0);
        check("rst_be", o_dbus_be, 0);
        check("rst_stall", o_stall_m, 0);
        @(negedge i_clk);
        i_rstn = 1;
        @(posedge i_clk);
        #1;

        // directed cases
        run_op(mk(3'd2, 0, 32'h104, 32'hDEAD_BEEF, 0, 0, 1, -1));          // SW, same-cycle gnt
        run_op(mk(3'd0, 1, 32'h103, 0, 32'h80FF_0000, 2, 1, -1));          // LB -> FFFFFF80, 3 stalls
        run_op(mk(3'd1, 0, 32'h201, 32'h1234, 0, 0, 1, -1));               // SH misaligned
        run_op(mk(3'd5, 1, 32'h202, 0, 32'h8001_0000, 0, 1, -1));          // LHU -> 00008001
        run_op(mk(3'd0, 0, 32'h003, 32'h12, 0, 0, 1, -1));                 // SB lane 3
        run_op(mk(3'd2, 1, 32'h400, 0, 32'h1111_2222, 0, 3, 1));           // flush in RESP
        run_op(mk(3'd2, 0, 32'h408, 32'h5555_AAAA, 0, 2, 1, 0));           // flush in IDLE, no gnt
        run_op(mk(3'd1, 1, 32'h10A, 0, 32'h9ABC_0000, 1, 2, -1));          // LH sign-extended
        run_op(mk(3'd2, 1, 32'h10E, 0, 0, 0, 1, -1));                      // LW misaligned
        run_op(mk(3'd3, 1, 32'h110, 0, 0, 0, 1, -1));                      // LD illegal on RV32
        run_op(mk(3'd4, 1, 32'h111, 0, 32'h0000_F700, 0, 1, -1));          // LBU lane 1
        run_op(mk(3'd1, 0, 32'h112, 32'hCAFE_BEEF, 0, 1, 1, -1));          // SH upper half, 1 wait

        // reset while a load waits for grant
        i_valid_m = 1; i_mem_read_m = 1; i_reg_write_m = 1;
        i_funct3_m = 3'd2; i_alu_result_m = 32'h500;
        @(negedge i_clk);
        check("r6_req_idle", o_dbus_req, 1);
        check("r6_stall_idle", o_stall_m, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("r6_req_in_req", o_dbus_req, 1);
        #1;
        i_rstn = 0;
        #1;
        check("r6_req_after_rst", o_dbus_req, 0);
        check("r6_stall_after_rst", o_stall_m, 0);
        check("r6_valid_w_after_rst", o_valid_w, 0);
        idle_inputs();
        @(negedge i_clk);
        i_rstn = 1;
        @(posedge i_clk);
        #1;
        run_op(mk(3'd2, 1, 32'h504, 0, 32'h1234_5678, 1, 2, -1));          // LW after reset

        // random legal traffic
        for (int i = 0; i < 24; i++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] a;
            ld = $urandom_range(0, 1);
            case ($urandom_range(0, ld ? 4 : 2))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            a = $urandom;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            o = mk(f3, ld, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(1, 2), -1);
            run_op(o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
